// File: rtl/rr_mux_if.sv
// Handshake bundle for the round-robin mux:
// NCH input channels in, one registered channel out.
interface rr_mux_if #(
   parameter int WIDTH = 5,
   parameter int NCH   = 4
);
   localparam int SELW = $clog2(NCH);

   logic [NCH-1:0]       in_valid;
   logic [NCH*WIDTH-1:0] in_data;
   logic [NCH-1:0]       in_ready;
   logic                 out_valid;
   logic [WIDTH-1:0]     out_data;
   logic [SELW-1:0]      out_sel;
   logic                 out_ready;

   modport slave (
      input  in_valid,
      input  in_data,
      input  out_ready,
      output in_ready,
      output out_valid,
      output out_data,
      output out_sel
   );

   modport master (
      output in_valid,
      output in_data,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  out_data,
      input  out_sel
   );
endinterface

// File: rtl/rr_mux.sv
// Round-robin N:1 mux with a single registered
// output stage and one-cycle latency.
module rr_mux #(
   parameter int WIDTH = 5,
   parameter int NCH   = 4
) (
   input  logic     clk,
   input  logic     rst_n,
   rr_mux_if.slave  bus
);
   localparam int SELW = $clog2(NCH);

   logic             out_valid_q;
   logic             out_valid_d;
   logic [WIDTH-1:0] out_data_q;
   logic [WIDTH-1:0] out_data_d;
   logic [SELW-1:0]  out_sel_q;
   logic [SELW-1:0]  out_sel_d;
   logic [SELW-1:0]  ptr_q;
   logic [SELW-1:0]  ptr_d;

   logic [NCH-1:0]   in_ready_c;
   logic [SELW-1:0]  gnt;
   logic             found;
   logic             free;
   logic             xfer;
   int               idx;

   // Search starts one past the last grant and wraps.
   always_comb begin
      found = 1'b0;
      gnt   = '0;
      idx   = 0;
      for (int k = 1; k <= NCH; k++) begin
         idx = (int'(ptr_q) + k) % NCH;
         if (!found && bus.in_valid[idx]) begin
            found = 1'b1;
            gnt   = SELW'(idx);
         end
      end
   end

   always_comb begin
      free        = !out_valid_q || bus.out_ready;
      xfer        = rst_n && free && found;
      in_ready_c  = '0;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
      if (xfer) begin
         in_ready_c[gnt] = 1'b1;
         out_valid_d     = 1'b1;
         out_data_d      = bus.in_data[int'(gnt)*WIDTH +: WIDTH];
         out_sel_d       = gnt;
         ptr_d           = gnt;
      end else if (free) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= SELW'(NCH - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_rr_mux.sv
// Directed bench for rr_mux (WIDTH=5, NCH=4):
// hand-computed grants, stalls, wrap and reset.
module tb_rr_mux;
   logic clk;
   logic rst_n;
   int   nvec;
   int   nerr;

   rr_mux_if #(.WIDTH(5), .NCH(4)) bus ();

   rr_mux #(.WIDTH(5), .NCH(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   logic [1:0] seq_a [5];
   logic [1:0] seq_b [3];

   initial begin
      nvec = 0;
      nerr = 0;
      seq_a = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
      seq_b = '{2'd0, 2'd3, 2'd0};

      rst_n         = 1'b0;
      bus.in_valid  = 4'b1111;
      bus.in_data   = {5'h04, 5'h03, 5'h02, 5'h01};
      bus.out_ready = 1'b1;
      #2;
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data", 32'(bus.out_data), 32'd0);
      chk("rst_sel", 32'(bus.out_sel), 32'd0);
      chk("rst_ready", 32'(bus.in_ready), 32'd0);
      tick();
      chk("rst_edge_valid", 32'(bus.out_valid), 32'd0);

      #2;
      rst_n        = 1'b1;
      bus.in_valid = 4'b0100;
      bus.in_data  = {5'h00, 5'h15, 5'h00, 5'h00};
      #1;
      chk("single_ready", 32'(bus.in_ready), 32'h4);
      tick();
      chk("single_valid", 32'(bus.out_valid), 32'd1);
      chk("single_data", 32'(bus.out_data), 32'h15);
      chk("single_sel", 32'(bus.out_sel), 32'd2);

      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 32'(bus.out_valid), 32'd0);
      chk("async_data", 32'(bus.out_data), 32'd0);
      chk("async_sel", 32'(bus.out_sel), 32'd0);
      #1;
      rst_n        = 1'b1;
      bus.in_valid = 4'b1111;
      bus.in_data  = {5'h04, 5'h03, 5'h02, 5'h01};
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("rr_ready", 32'(bus.in_ready),
             32'd1 << seq_a[i]);
         tick();
         chk("rr_valid", 32'(bus.out_valid), 32'd1);
         chk("rr_sel", 32'(bus.out_sel), 32'(seq_a[i]));
         chk("rr_data", 32'(bus.out_data),
             32'(seq_a[i]) + 32'd1);
      end

      bus.in_valid = 4'b0010;
      bus.in_data  = {5'h04, 5'h03, 5'h0A, 5'h01};
      #1;
      chk("hold_load_ready", 32'(bus.in_ready), 32'h2);
      tick();
      chk("hold_load_data", 32'(bus.out_data), 32'h0A);
      bus.out_ready = 1'b0;
      bus.in_valid  = 4'b1111;
      bus.in_data   = {5'h04, 5'h03, 5'h1F, 5'h01};
      repeat (3) begin
         #1;
         chk("stall_ready", 32'(bus.in_ready), 32'd0);
         tick();
         chk("stall_valid", 32'(bus.out_valid), 32'd1);
         chk("stall_data", 32'(bus.out_data), 32'h0A);
         chk("stall_sel", 32'(bus.out_sel), 32'd1);
      end
      bus.out_ready = 1'b1;
      #1;
      chk("resume_ready", 32'(bus.in_ready), 32'h4);
      tick();
      chk("resume_sel", 32'(bus.out_sel), 32'd2);
      chk("resume_data", 32'(bus.out_data), 32'h03);

      bus.in_valid = 4'b1000;
      #1;
      chk("to3_ready", 32'(bus.in_ready), 32'h8);
      tick();
      chk("to3_sel", 32'(bus.out_sel), 32'd3);
      chk("to3_data", 32'(bus.out_data), 32'h04);
      bus.in_valid = 4'b1001;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("wrap_ready", 32'(bus.in_ready),
             32'd1 << seq_b[i]);
         tick();
         chk("wrap_sel", 32'(bus.out_sel), 32'(seq_b[i]));
         chk("wrap_valid", 32'(bus.out_valid), 32'd1);
      end

      bus.in_valid = 4'b0000;
      #1;
      chk("idle_ready", 32'(bus.in_ready), 32'd0);
      repeat (2) begin
         tick();
         chk("idle_valid", 32'(bus.out_valid), 32'd0);
         chk("idle_data", 32'(bus.out_data), 32'h01);
         chk("idle_sel", 32'(bus.out_sel), 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               nvec, nerr);
      $finish;
   end
endmodule
